// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundles the decode-side read/reservation signals and the
// writeback-side write signals of the register file.
//   master modport : pipeline side (drives addresses, writes, reservations)
//   slave modport  : register file side (returns read data and busy flags)
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data1;
  logic              rd_busy1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy2;
  logic              wr_en_a;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [DATA_W-1:0] wr_data_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_b;
  logic              sb_set;
  logic [ADDR_W-1:0] sb_addr;
  logic              flush;
  logic              busy_any;

  modport master (
    output rd_addr1, rd_addr2,
    output wr_en_a, wr_addr_a, wr_data_a,
    output wr_en_b, wr_addr_b, wr_data_b,
    output sb_set, sb_addr, flush,
    input  rd_data1, rd_busy1, rd_data2, rd_busy2, busy_any
  );

  modport slave (
    input  rd_addr1, rd_addr2,
    input  wr_en_a, wr_addr_a, wr_data_a,
    input  wr_en_b, wr_addr_b, wr_data_b,
    input  sb_set, sb_addr, flush,
    output rd_data1, rd_busy1, rd_data2, rd_busy2, busy_any
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports, two
// synchronous write ports (A = ALU writeback, B = late/load writeback) and a
// per-register busy scoreboard for hazard detection at decode.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous, active-high; clears registers and busy bits
//   bus   - regfile_sb_if.slave: read ports, write ports A/B, sb_set/sb_addr,
//           flush, busy_any
// Parameters: DATA_W, ADDR_W (depth 2**ADDR_W), BYPASS (same-cycle write
// data / busy clear visible on reads), ZERO_REG (register 0 reads as zero).
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic we_a;
  logic we_b;
  logic set_ok;

  // Address 0 is write-protected and never reservable when hardwired.
  assign we_a   = bus.wr_en_a && !(ZERO_REG != 0 && bus.wr_addr_a == '0);
  assign we_b   = bus.wr_en_b && !(ZERO_REG != 0 && bus.wr_addr_b == '0);
  assign set_ok = bus.sb_set  && !(ZERO_REG != 0 && bus.sb_addr   == '0);

  // Flush beats everything; a reservation beats a same-address port B clear.
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      if (bus.wr_en_b) busy_nxt[bus.wr_addr_b] = 1'b0;
      if (set_ok)      busy_nxt[bus.sb_addr]   = 1'b1;
    end
  end

  // Port A is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      busy <= busy_nxt;
      if (we_b) regs[bus.wr_addr_b] <= bus.wr_data_b;
      if (we_a) regs[bus.wr_addr_a] <= bus.wr_data_a;
    end
  end

  function automatic logic [DATA_W-1:0] sel_data(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              en_a,
    input logic [ADDR_W-1:0] addr_a,
    input logic [DATA_W-1:0] data_a,
    input logic              en_b,
    input logic [ADDR_W-1:0] addr_b,
    input logic [DATA_W-1:0] data_b
  );
    logic [DATA_W-1:0] d;
    d = stored;
    if (BYPASS != 0) begin
      if (en_b && addr_b == addr) d = data_b;
      if (en_a && addr_a == addr) d = data_a;
    end
    if (ZERO_REG != 0 && addr == '0) d = '0;
    return d;
  endfunction

  function automatic logic sel_busy(
    input logic [ADDR_W-1:0] addr,
    input logic              stored,
    input logic              en_b,
    input logic [ADDR_W-1:0] addr_b
  );
    logic b;
    b = stored;
    // Only the port B clear is forwarded; a new reservation shows next cycle.
    if (BYPASS != 0 && en_b && addr_b == addr) b = 1'b0;
    if (ZERO_REG != 0 && addr == '0) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    bus.rd_data1 = sel_data(bus.rd_addr1, regs[bus.rd_addr1],
                            bus.wr_en_a, bus.wr_addr_a, bus.wr_data_a,
                            bus.wr_en_b, bus.wr_addr_b, bus.wr_data_b);
    bus.rd_data2 = sel_data(bus.rd_addr2, regs[bus.rd_addr2],
                            bus.wr_en_a, bus.wr_addr_a, bus.wr_data_a,
                            bus.wr_en_b, bus.wr_addr_b, bus.wr_data_b);
    bus.rd_busy1 = sel_busy(bus.rd_addr1, busy[bus.rd_addr1],
                            bus.wr_en_b, bus.wr_addr_b);
    bus.rd_busy2 = sel_busy(bus.rd_addr2, busy[bus.rd_addr2],
                            bus.wr_en_b, bus.wr_addr_b);
    bus.busy_any = |busy;
  end
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  logic clk;
  logic reset;

  int n_vec;
  int n_err;

  // dut1: BYPASS=1, ZERO_REG=1   dut0: BYPASS=0, ZERO_REG=0 (same stimulus)
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifc1 ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifc0 ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset(reset), .bus(ifc1.slave));
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset), .bus(ifc0.slave));

  assign ifc0.rd_addr1  = ifc1.rd_addr1;
  assign ifc0.rd_addr2  = ifc1.rd_addr2;
  assign ifc0.wr_en_a   = ifc1.wr_en_a;
  assign ifc0.wr_addr_a = ifc1.wr_addr_a;
  assign ifc0.wr_data_a = ifc1.wr_data_a;
  assign ifc0.wr_en_b   = ifc1.wr_en_b;
  assign ifc0.wr_addr_b = ifc1.wr_addr_b;
  assign ifc0.wr_data_b = ifc1.wr_data_b;
  assign ifc0.sb_set    = ifc1.sb_set;
  assign ifc0.sb_addr   = ifc1.sb_addr;
  assign ifc0.flush     = ifc1.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, index 1 = bypass/zero-reg config, index 0 = plain config.
  logic [31:0] m_r [2][32];
  bit          m_b [2][32];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_r[c][i] = 32'h0;
        m_b[c][i] = 1'b0;
      end
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < 2; c++) begin
      bit z;
      z = (c == 1);
      if (ifc1.flush) begin
        for (int i = 0; i < 32; i++) m_b[c][i] = 1'b0;
      end else begin
        if (ifc1.wr_en_b) m_b[c][ifc1.wr_addr_b] = 1'b0;
        if (ifc1.sb_set && !(z && ifc1.sb_addr == 0)) m_b[c][ifc1.sb_addr] = 1'b1;
      end
      if (ifc1.wr_en_b && !(z && ifc1.wr_addr_b == 0)) m_r[c][ifc1.wr_addr_b] = ifc1.wr_data_b;
      if (ifc1.wr_en_a && !(z && ifc1.wr_addr_a == 0)) m_r[c][ifc1.wr_addr_a] = ifc1.wr_data_a;
    end
  endfunction

  function automatic logic [31:0] exp_d(input int c, input logic [4:0] a);
    if (c == 1) begin
      if (a == 0) return 32'h0;
      if (ifc1.wr_en_a && ifc1.wr_addr_a == a) return ifc1.wr_data_a;
      if (ifc1.wr_en_b && ifc1.wr_addr_b == a) return ifc1.wr_data_b;
    end
    return m_r[c][a];
  endfunction

  function automatic logic exp_b(input int c, input logic [4:0] a);
    if (c == 1) begin
      if (a == 0) return 1'b0;
      if (ifc1.wr_en_b && ifc1.wr_addr_b == a) return 1'b0;
    end
    return m_b[c][a];
  endfunction

  function automatic logic exp_any(input int c);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 32; i++) r = r | m_b[c][i];
    return r;
  endfunction

  function automatic logic [133:0] exp_vec();
    return {exp_d(1, ifc1.rd_addr1), exp_b(1, ifc1.rd_addr1),
            exp_d(1, ifc1.rd_addr2), exp_b(1, ifc1.rd_addr2), exp_any(1),
            exp_d(0, ifc1.rd_addr1), exp_b(0, ifc1.rd_addr1),
            exp_d(0, ifc1.rd_addr2), exp_b(0, ifc1.rd_addr2), exp_any(0)};
  endfunction

  function automatic logic [133:0] obs_vec();
    return {ifc1.rd_data1, ifc1.rd_busy1, ifc1.rd_data2, ifc1.rd_busy2, ifc1.busy_any,
            ifc0.rd_data1, ifc0.rd_busy1, ifc0.rd_data2, ifc0.rd_busy2, ifc0.busy_any};
  endfunction

  task automatic idle();
    ifc1.wr_en_a = 1'b0; ifc1.wr_addr_a = '0; ifc1.wr_data_a = '0;
    ifc1.wr_en_b = 1'b0; ifc1.wr_addr_b = '0; ifc1.wr_data_b = '0;
    ifc1.sb_set = 1'b0; ifc1.sb_addr = '0; ifc1.flush = 1'b0;
  endtask

  // One rising edge; model follows the DUT state update, then inputs may change.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    logic [133:0] e;
    logic [133:0] o;
    reset = 1'b1;
    idle();
    ifc1.rd_addr1 = '0; ifc1.rd_addr2 = '0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ifc1.rd_addr1 = 5'(i);
      ifc1.rd_addr2 = 5'(31 - i);
      settle();
      e = exp_vec(); o = obs_vec();
      n_vec++;
      if (o !== e || o !== '0) begin
        $display("FAIL reset_read[%0d] got %h expected %h", i, o, e);
        n_err++;
      end
    end
    tick();
    ifc1.wr_en_a = 1'b1; ifc1.wr_addr_a = 5'd5; ifc1.wr_data_a = 32'h1234;
    #2;
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    idle();
    ifc1.rd_addr1 = 5'd5;
    settle();
    n_vec++;
    if (ifc1.rd_data1 !== 32'h0 || ifc0.rd_data1 !== 32'h0) begin
      $display("FAIL reset_mid_write r5 got %h/%h expected 0", ifc1.rd_data1, ifc0.rd_data1);
      n_err++;
    end
  endtask

  task automatic test_write();
    ifc1.wr_en_a = 1'b1; ifc1.wr_addr_a = 5'd3; ifc1.wr_data_a = 32'hDEADBEEF;
    tick();
    idle();
    ifc1.rd_addr1 = 5'd3;
    settle();
    n_vec++;
    if (ifc1.rd_data1 !== 32'hDEADBEEF || ifc0.rd_data1 !== 32'hDEADBEEF) begin
      $display("FAIL write_a_r3 got %h/%h expected deadbeef", ifc1.rd_data1, ifc0.rd_data1);
      n_err++;
    end
    ifc1.wr_en_b = 1'b1; ifc1.wr_addr_b = 5'd0; ifc1.wr_data_b = 32'hFFFFFFFF;
    tick();
    idle();
    ifc1.rd_addr1 = 5'd0;
    settle();
    n_vec++;
    if (ifc1.rd_data1 !== 32'h0 || ifc1.rd_busy1 !== 1'b0) begin
      $display("FAIL zero_reg got data %h busy %b expected 0 0", ifc1.rd_data1, ifc1.rd_busy1);
      n_err++;
    end
    n_vec++;
    if (ifc0.rd_data1 !== 32'hFFFFFFFF) begin
      $display("FAIL r0_plain got %h expected ffffffff", ifc0.rd_data1);
      n_err++;
    end
  endtask

  task automatic test_collision();
    ifc1.wr_en_a = 1'b1; ifc1.wr_addr_a = 5'd7; ifc1.wr_data_a = 32'h77;
    tick();
    ifc1.wr_data_a = 32'h11111111;
    ifc1.wr_en_b = 1'b1; ifc1.wr_addr_b = 5'd7; ifc1.wr_data_b = 32'h22222222;
    ifc1.rd_addr1 = 5'd7;
    settle();
    n_vec++;
    if (ifc1.rd_data1 !== 32'h11111111) begin
      $display("FAIL collision_bypass got %h expected 11111111", ifc1.rd_data1);
      n_err++;
    end
    n_vec++;
    if (ifc0.rd_data1 !== 32'h77) begin
      $display("FAIL collision_nobypass got %h expected 00000077", ifc0.rd_data1);
      n_err++;
    end
    tick();
    idle();
    settle();
    n_vec++;
    if (ifc1.rd_data1 !== 32'h11111111 || ifc0.rd_data1 !== 32'h11111111) begin
      $display("FAIL collision_stored got %h/%h expected 11111111", ifc1.rd_data1, ifc0.rd_data1);
      n_err++;
    end
  endtask

  task automatic test_scoreboard();
    ifc1.sb_set = 1'b1; ifc1.sb_addr = 5'd9;
    ifc1.rd_addr1 = 5'd9;
    settle();
    n_vec++;
    if (ifc1.rd_busy1 !== 1'b0 || ifc1.busy_any !== 1'b0) begin
      $display("FAIL set_not_bypassed got busy %b any %b expected 0 0", ifc1.rd_busy1, ifc1.busy_any);
      n_err++;
    end
    tick();
    idle();
    settle();
    n_vec++;
    if (ifc1.rd_busy1 !== 1'b1 || ifc1.busy_any !== 1'b1 || ifc0.rd_busy1 !== 1'b1) begin
      $display("FAIL sb_set_r9 got busy %b any %b plain %b expected 1 1 1",
               ifc1.rd_busy1, ifc1.busy_any, ifc0.rd_busy1);
      n_err++;
    end
    ifc1.wr_en_b = 1'b1; ifc1.wr_addr_b = 5'd9; ifc1.wr_data_b = 32'hCAFE0000;
    settle();
    n_vec++;
    if (ifc1.rd_busy1 !== 1'b0 || ifc1.rd_data1 !== 32'hCAFE0000 || ifc1.busy_any !== 1'b1) begin
      $display("FAIL release_bypass got busy %b data %h any %b expected 0 cafe0000 1",
               ifc1.rd_busy1, ifc1.rd_data1, ifc1.busy_any);
      n_err++;
    end
    n_vec++;
    if (ifc0.rd_busy1 !== 1'b1 || ifc0.rd_data1 !== 32'h0) begin
      $display("FAIL release_nobypass got busy %b data %h expected 1 00000000",
               ifc0.rd_busy1, ifc0.rd_data1);
      n_err++;
    end
    tick();
    idle();
    settle();
    n_vec++;
    if (ifc1.busy_any !== 1'b0 || ifc0.busy_any !== 1'b0) begin
      $display("FAIL release_busy_any got %b/%b expected 0", ifc1.busy_any, ifc0.busy_any);
      n_err++;
    end
  endtask

  task automatic test_set_vs_write();
    ifc1.sb_set = 1'b1; ifc1.sb_addr = 5'd4;
    ifc1.wr_en_b = 1'b1; ifc1.wr_addr_b = 5'd4; ifc1.wr_data_b = 32'h55;
    tick();
    idle();
    ifc1.rd_addr2 = 5'd4;
    settle();
    n_vec++;
    if (ifc1.rd_data2 !== 32'h55 || ifc1.rd_busy2 !== 1'b1 ||
        ifc0.rd_data2 !== 32'h55 || ifc0.rd_busy2 !== 1'b1) begin
      $display("FAIL set_beats_clear got %h %b / %h %b expected 00000055 1",
               ifc1.rd_data2, ifc1.rd_busy2, ifc0.rd_data2, ifc0.rd_busy2);
      n_err++;
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      ifc1.sb_set = 1'b1; ifc1.sb_addr = 5'(i);
      tick();
    end
    idle();
    ifc1.flush = 1'b1;
    ifc1.sb_set = 1'b1; ifc1.sb_addr = 5'd6;
    ifc1.wr_en_b = 1'b1; ifc1.wr_addr_b = 5'd10; ifc1.wr_data_b = 32'hABCD;
    tick();
    idle();
    ifc1.rd_addr1 = 5'd6; ifc1.rd_addr2 = 5'd10;
    settle();
    n_vec++;
    if (ifc1.busy_any !== 1'b0 || ifc1.rd_busy1 !== 1'b0 ||
        ifc0.busy_any !== 1'b0 || ifc0.rd_busy1 !== 1'b0) begin
      $display("FAIL flush_busy got any %b r6 %b / any %b r6 %b expected all 0",
               ifc1.busy_any, ifc1.rd_busy1, ifc0.busy_any, ifc0.rd_busy1);
      n_err++;
    end
    n_vec++;
    if (ifc1.rd_data2 !== 32'hABCD || ifc0.rd_data2 !== 32'hABCD) begin
      $display("FAIL flush_write got %h/%h expected 0000abcd", ifc1.rd_data2, ifc0.rd_data2);
      n_err++;
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [133:0] e;
    logic [133:0] o;
    for (int n = 0; n < 600; n++) begin
      ifc1.wr_en_a   = ($urandom_range(0, 1) == 1);
      ifc1.wr_addr_a = rnd_addr();
      ifc1.wr_data_a = $urandom;
      ifc1.wr_en_b   = ($urandom_range(0, 1) == 1);
      ifc1.wr_addr_b = rnd_addr();
      ifc1.wr_data_b = $urandom;
      ifc1.sb_set    = ($urandom_range(0, 2) == 0);
      ifc1.sb_addr   = rnd_addr();
      ifc1.flush     = ($urandom_range(0, 15) == 0);
      ifc1.rd_addr1  = rnd_addr();
      ifc1.rd_addr2  = rnd_addr();
      settle();
      e = exp_vec(); o = obs_vec();
      n_vec++;
      if (o !== e) begin
        $display("FAIL random[%0d] got %h expected %h", n, o, e);
        n_err++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    idle();
    ifc1.rd_addr1 = '0;
    ifc1.rd_addr2 = '0;
    #1;
    test_reset();
    test_write();
    test_collision();
    test_scoreboard();
    test_set_vs_write();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
